// File: rtl/ad_dac_tx_if.sv
// ad_dac_tx_if: AXI4-Stream sample channel feeding the DAC transmitter.
interface ad_dac_tx_if #(parameter int DW = 12) ();
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready;
    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/ad_dac_tx.sv
// ad_dac_tx: AXI4-Stream to parallel DAC transmitter with sample FIFO, divided DAC clock and underflow count.
// Optional AD_DAC_OFFSET_BINARY_EN: stream carries two's complement, converted to offset binary on pop.
module ad_dac_tx #(
    parameter int DAC_DATA_WIDTH = 12,
    parameter int CLK_DIV        = 4,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    ad_dac_tx_if.slave                    s_axis,
    output logic                          dac_clk,
    output logic [DAC_DATA_WIDTH-1:0]     dac_data,
    output logic                          underflow,
    output logic [15:0]                   underflow_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int DW = DAC_DATA_WIDTH;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] MID = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [LW-1:0]   level_q, level_d;
    logic            dac_clk_q, dac_clk_d;
    logic [DW-1:0]   dac_data_q, dac_data_d;
    logic            underflow_q, underflow_d;
    logic [15:0]     ucnt_q, ucnt_d;
    logic [DW-1:0]   mem_q [FIFO_DEPTH];
    logic            full, empty, run, tick, push, pop;
    logic [DW-1:0]   head;

    assign full          = level_q == LW'(FIFO_DEPTH);
    assign empty         = level_q == '0;
    assign s_axis.tready = state_q != IDLE && !full;
    assign run           = state_q == RUN && enable;
    assign tick          = run && cnt_q == CW'(CLK_DIV - 1);
    assign push          = s_axis.tvalid && s_axis.tready && enable;
    assign pop           = tick && !empty;
`ifdef AD_DAC_OFFSET_BINARY_EN
    assign head = {~mem_q[rd_q][DW-1], mem_q[rd_q][DW-2:0]};
`else
    assign head = mem_q[rd_q];
`endif

    always_comb begin
        state_d     = !enable ? IDLE :
                      state_q == IDLE ? PRIME :
                      (state_q == PRIME && level_q >= LW'(FIFO_DEPTH / 2)) ? RUN : state_q;
        cnt_d       = run ? (tick ? '0 : cnt_q + CW'(1)) : '0;
        dac_clk_d   = run && cnt_d >= CW'(CLK_DIV / 2);
        // Dropping enable flushes the FIFO outright, whatever is in flight this cycle.
        wr_d        = enable ? wr_q + AW'(push) : '0;
        rd_d        = enable ? rd_q + AW'(pop) : '0;
        level_d     = enable ? level_q + LW'(push) - LW'(pop) : '0;
        dac_data_d  = !run ? MID : tick ? (empty ? MID : head) : dac_data_q;
        underflow_d = tick && empty;
        ucnt_d      = (!enable || state_q == IDLE) ? '0 :
                      (underflow_d && ucnt_q != 16'hFFFF) ? ucnt_q + 16'd1 : ucnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            wr_q        <= '0;
            rd_q        <= '0;
            level_q     <= '0;
            dac_clk_q   <= 1'b0;
            dac_data_q  <= MID;
            underflow_q <= 1'b0;
            ucnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            level_q     <= level_d;
            dac_clk_q   <= dac_clk_d;
            dac_data_q  <= dac_data_d;
            underflow_q <= underflow_d;
            ucnt_q      <= ucnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= s_axis.tdata;
    end

    assign dac_clk       = dac_clk_q;
    assign dac_data      = dac_data_q;
    assign underflow     = underflow_q;
    assign underflow_cnt = ucnt_q;
    assign fifo_level    = level_q;
endmodule
